mskand_ghpc_seq: RTL

- Sequencer for a bank of NLANE masked AND2 GHPC gadgets (d=2, fixed latency 2, no enable, clocked every cycle).
- Joins the operand stream with the fresh-randomness stream and issues one operation per cycle to all lanes.
- Tracks in-flight tokens and buffers results in a credit-controlled output FIFO, so downstream backpressure never drops a gadget result.
- Sits between the masked S-box datapath control and the gadget bank instances, which are instantiated inside this block.

---
 rtl/mskand_seq_pkg.sv | 12 +
 rtl/mskand_ghpc_and2.sv | 19 +
 rtl/mskand_seq_fifo.sv | 50 +++++
 rtl/mskand_ghpc_seq.sv | 103 ++++++++++
 4 files changed

// File: rtl/mskand_seq_pkg.sv
// Shared constants and the lane/share bit-index helper for the masked AND2 sequencer.
package mskand_seq_pkg;

  localparam int unsigned GHPC_LAT = 2;
  localparam int unsigned D_SHARES = 2;

  // Lane i, share s lives at bit 2i+s of every sharing bus.
  function automatic int unsigned sh_idx(input int unsigned lane, input int unsigned share);
    return D_SHARES * lane + share;
  endfunction

endpackage

// File: rtl/mskand_ghpc_and2.sv
// Masked AND2 gadget, d=2, fixed two-cycle latency, no enable, no reset.
module mskand_ghpc_and2 (
  input  logic       clk,
  input  logic [1:0] ina,
  input  logic [1:0] inb,
  input  logic       rnd,
  output logic [1:0] outc
);

  logic [3:0] cross_q;

  // Cross-domain products are refreshed with rnd before the register barrier.
  always_ff @(posedge clk) begin
    cross_q <= {ina[1] & inb[1], (ina[1] & inb[0]) ^ rnd,
                (ina[0] & inb[1]) ^ rnd, ina[0] & inb[0]};
    outc    <= {cross_q[3] ^ cross_q[2], cross_q[1] ^ cross_q[0]};
  end

endmodule

// File: rtl/mskand_seq_fifo.sv
// Circular result buffer with occupancy count and first-word read.
module mskand_seq_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) wr_en |-> (cnt < CW'(DEPTH)));

endmodule

// File: rtl/mskand_ghpc_seq.sv
// Issue sequencer for a bank of masked AND2 gadgets with credit-controlled result FIFO.
// Define MSKAND_GHPC_SEQ_STALL_CNT_EN to add the randomness-starvation counter.
module mskand_ghpc_seq
  import mskand_seq_pkg::*;
#(
  parameter int unsigned d      = 2,
  parameter int unsigned NLANE  = 8,
  parameter int unsigned FDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*NLANE-1:0]     in_a,
  input  logic [2*NLANE-1:0]     in_b,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [NLANE-1:0]       rnd_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NLANE-1:0]     out_c,
`ifdef MSKAND_GHPC_SEQ_STALL_CNT_EN
  input  logic                   stall_clr,
  output logic [15:0]            stall_cnt,
`endif
  output logic                   busy
);

  localparam int unsigned W  = D_SHARES * NLANE;
  localparam int unsigned CW = $clog2(FDEPTH) + 1;

  if (d != D_SHARES) begin : g_bad_d
    $error("mskand_ghpc_seq supports only d = 2");
  end
  if (FDEPTH < GHPC_LAT + 1) begin : g_bad_fdepth
    $error("mskand_ghpc_seq needs FDEPTH >= GHPC_LAT + 1");
  end

  logic [GHPC_LAT-1:0] vpipe;
  logic [CW-1:0]       fifo_cnt;
  logic [CW:0]         occupancy;
  logic                credit_ok;
  logic                fire;
  logic [W-1:0]        gad_a;
  logic [W-1:0]        gad_b;
  logic [NLANE-1:0]    gad_r;
  logic [W-1:0]        bank_c;

  // Credits cover both buffered and in-flight beats, so every landing result has a slot.
  always_comb begin
    occupancy = (CW+1)'(fifo_cnt) + (CW+1)'($countones(vpipe));
    credit_ok = !rst && (occupancy < (CW+1)'(FDEPTH));
    fire      = in_valid & rnd_valid & credit_ok;
    gad_a     = fire ? in_a   : '0;
    gad_b     = fire ? in_b   : '0;
    gad_r     = fire ? rnd_in : '0;
  end

  assign in_ready  = rnd_valid & credit_ok;
  assign rnd_ready = in_valid & credit_ok;
  assign out_valid = (fifo_cnt != '0);
  assign busy      = (vpipe != '0) | (fifo_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[GHPC_LAT-2:0], fire};
  end

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    mskand_ghpc_and2 u_gadget (
      .clk  (clk),
      .ina  (gad_a[sh_idx(i, 1):sh_idx(i, 0)]),
      .inb  (gad_b[sh_idx(i, 1):sh_idx(i, 0)]),
      .rnd  (gad_r[i]),
      .outc (bank_c[sh_idx(i, 1):sh_idx(i, 0)])
    );
  end

  mskand_seq_fifo #(
    .WIDTH (W),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vpipe[GHPC_LAT-1]),
    .wr_data (bank_c),
    .rd_en   (out_valid & out_ready),
    .rd_data (out_c),
    .cnt     (fifo_cnt)
  );

`ifdef MSKAND_GHPC_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (in_valid && !rnd_valid && credit_ok && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
